ctr_reload: RTL and testbench



---
 rtl/ctr_reload.sv | 84 ++++++++
 tb/tb_ctr_reload.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/ctr_reload.sv
// Programmable up/down counter with a reload register, one-shot or auto-reload
// modes, a registered terminal-count pulse and a combinational cascade carry.
module ctr_reload #(
  parameter int WIDTH = 7
) (
  input  logic             MasterClock,
  input  logic             RESET,
  input  logic             XCK,
  input  logic [WIDTH-1:0] D,
  input  logic             LDL,
  input  logic             ENAB,
  input  logic             DN,
  input  logic             AUTO,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QL,
  output logic             CO,
  output logic             TC,
  output logic             RUN
);

  logic [WIDTH-1:0] q_reg, q_next;
  logic [WIDTH-1:0] r_reg, r_next;
  logic             run_reg, run_next;
  logic             tc_reg, tc_next;
  logic             term;
  logic             cnt;

  // Terminal value depends on the current direction, so a DN change mid-count
  // moves the terminal point on the very next tick.
  assign term = DN ? (q_reg == '0) : (q_reg == '1);
  assign cnt  = LDL & ENAB & (AUTO | run_reg);

  always_comb begin
    q_next   = q_reg;
    r_next   = r_reg;
    run_next = run_reg;
    tc_next  = 1'b0;
    if (XCK) begin
      if (!LDL) begin
        q_next   = D;
        r_next   = D;
        run_next = 1'b1;
      end else if (cnt) begin
        if (term) begin
          tc_next = 1'b1;
          if (AUTO) begin
            q_next = r_reg;
          end else begin
            run_next = 1'b0;
          end
        end else if (DN) begin
          q_next = q_reg - 1'b1;
        end else begin
          q_next = q_reg + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge MasterClock) begin
    if (RESET) begin
      q_reg   <= '0;
      r_reg   <= '0;
      run_reg <= 1'b0;
      tc_reg  <= 1'b0;
    end else begin
      q_reg   <= q_next;
      r_reg   <= r_next;
      run_reg <= run_next;
      tc_reg  <= tc_next;
    end
  end

  // CO is deliberately unregistered so a cascaded stage advances on the same edge.
  assign CO  = cnt & term;
  assign Q   = q_reg;
  assign TC  = tc_reg;
  assign RUN = run_reg;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ql
    assign QL[gi] = ~q_reg[gi];
  end

endmodule

// File: tb/tb_ctr_reload.sv
// Self-checking bench for ctr_reload: a 7-bit instance against a behavioural
// model through a scoreboard queue, plus a two-stage 4-bit cascade.
module tb_ctr_reload;

  logic       clk = 1'b0;
  logic       rst, xck, ldl, enab, dn, auto;
  logic [6:0] d;
  logic [6:0] q, ql;
  logic       co, tc, run;

  // cascade pair
  logic       c_rst, c_xck;
  logic [3:0] lo_q, lo_ql, hi_q, hi_ql;
  logic       lo_co, lo_tc, lo_run, hi_co, hi_tc, hi_run;

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct {
    logic [6:0] q;
    logic       tc;
    logic       run;
  } exp_t;

  exp_t sb[$];
  int   csb[$];

  // model state
  int m_q, m_r, m_run, m_tc;

  always #5 clk = ~clk;

  ctr_reload #(.WIDTH(7)) dut (
    .MasterClock(clk), .RESET(rst), .XCK(xck), .D(d), .LDL(ldl), .ENAB(enab),
    .DN(dn), .AUTO(auto), .Q(q), .QL(ql), .CO(co), .TC(tc), .RUN(run)
  );

  ctr_reload #(.WIDTH(4)) u_lo (
    .MasterClock(clk), .RESET(c_rst), .XCK(c_xck), .D(4'h0), .LDL(1'b1), .ENAB(1'b1),
    .DN(1'b0), .AUTO(1'b1), .Q(lo_q), .QL(lo_ql), .CO(lo_co), .TC(lo_tc), .RUN(lo_run)
  );

  ctr_reload #(.WIDTH(4)) u_hi (
    .MasterClock(clk), .RESET(c_rst), .XCK(c_xck), .D(4'h0), .LDL(1'b1), .ENAB(lo_co),
    .DN(1'b0), .AUTO(1'b1), .Q(hi_q), .QL(hi_ql), .CO(hi_co), .TC(hi_tc), .RUN(hi_run)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  // One transaction: apply inputs, check CO before the edge, push the model's
  // post-edge state, then pop and compare after the edge.
  task automatic step(input logic r_i, input logic x_i, input logic l_i, input logic e_i,
                      input logic dn_i, input logic a_i, input int d_i);
    int   term, cnt;
    exp_t e, got;
    rst = r_i; xck = x_i; ldl = l_i; enab = e_i; dn = dn_i; auto = a_i; d = d_i[6:0];
    #1;
    term = dn_i ? (m_q == 0) : (m_q == 127);
    cnt  = (l_i && e_i && (a_i || m_run != 0)) ? 1 : 0;
    if (!r_i) check_eq("co", {31'b0, co}, (cnt != 0 && term != 0) ? 1 : 0);
    if (r_i) begin
      m_q = 0; m_r = 0; m_run = 0; m_tc = 0;
    end else begin
      m_tc = 0;
      if (x_i) begin
        if (!l_i) begin
          m_q = d_i % 128; m_r = d_i % 128; m_run = 1;
        end else if (cnt != 0) begin
          if (term != 0) begin
            m_tc = 1;
            if (a_i) m_q = m_r;
            else m_run = 0;
          end else begin
            m_q = (m_q + (dn_i ? 127 : 1)) % 128;
          end
        end
      end
    end
    e.q = m_q[6:0]; e.tc = m_tc[0]; e.run = m_run[0];
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check_eq("q", {25'b0, q}, {25'b0, got.q});
    check_eq("ql", {25'b0, ql}, {25'b0, ~got.q});
    check_eq("tc", {31'b0, tc}, {31'b0, got.tc});
    check_eq("run", {31'b0, run}, {31'b0, got.run});
    $display("txn rst=%b xck=%b ldl=%b en=%b dn=%b auto=%b d=%02h -> q=%02h tc=%b run=%b",
             r_i, x_i, l_i, e_i, dn_i, a_i, d_i[6:0], q, tc, run);
  endtask

  initial begin
    int c;
    rst = 1'b1; xck = 1'b0; ldl = 1'b1; enab = 1'b0; dn = 1'b0; auto = 1'b0; d = '0;
    c_rst = 1'b1; c_xck = 1'b0;
    @(posedge clk);
    #1;

    // reset with random inputs, then free-running auto count from 0
    step(1, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
         $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 127));
    for (int i = 0; i < 4; i++) step(0, 1, 1, 1, 0, 1, 0);

    // auto-reload up from 0x7D
    step(0, 1, 0, 1, 0, 1, 'h7D);
    for (int i = 0; i < 8; i++) step(0, 1, 1, 1, 0, 1, 0);

    // one-shot down from 3, then reload 2
    step(0, 1, 0, 1, 1, 0, 3);
    for (int i = 0; i < 6; i++) step(0, 1, 1, 1, 1, 0, 0);
    step(0, 1, 0, 1, 1, 0, 2);
    for (int i = 0; i < 4; i++) step(0, 1, 1, 1, 1, 0, 0);

    // one-shot down loaded with 0
    step(0, 1, 0, 1, 1, 0, 0);
    step(0, 1, 1, 1, 1, 0, 0);
    step(0, 1, 1, 1, 1, 0, 0);

    // tick gating: XCK every 4th cycle, ENAB low, load with XCK low
    step(0, 1, 0, 1, 0, 1, 0);
    for (int i = 0; i < 12; i++) step(0, (i % 4) == 3, 1, 1, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0, 1, 'h55);
    step(0, 0, 1, 1, 0, 1, 0);

    // terminal with XCK low, then load colliding with terminal
    step(0, 1, 0, 1, 0, 0, 'h7F);
    step(0, 0, 1, 1, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0, 'h10);
    step(0, 1, 1, 1, 0, 0, 0);

    // R = all ones, up, auto: TC every tick
    step(0, 1, 0, 1, 0, 1, 'h7F);
    for (int i = 0; i < 4; i++) step(0, 1, 1, 1, 0, 1, 0);

    // reset mid-count at 0x40 and with TC high
    step(0, 1, 0, 1, 0, 1, 'h40);
    step(1, 1, 1, 1, 0, 1, 0);
    step(0, 1, 0, 1, 0, 0, 'h7F);
    step(0, 1, 1, 1, 0, 0, 0);
    step(1, 1, 1, 1, 0, 0, 0);

    // direction change mid-count
    step(0, 1, 0, 1, 0, 1, 'h02);
    step(0, 1, 1, 1, 1, 1, 0);
    step(0, 1, 1, 1, 1, 1, 0);
    step(0, 1, 1, 1, 1, 1, 0);
    step(0, 1, 1, 1, 0, 1, 0);

    // random traffic
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 40) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 9) != 0,
           $urandom_range(0, 5) != 0, $urandom_range(0, 7) == 0 ? ~dn : dn,
           $urandom_range(0, 1), $urandom_range(0, 127));

    // cascade: two 4-bit stages, free-running from reset
    c_rst = 1'b1; c_xck = 1'b1;
    @(posedge clk);
    #1;
    c_rst = 1'b0;
    c = 0;
    check_eq("casc_rst", {24'b0, hi_q, lo_q}, 0);
    for (int i = 0; i < 270; i++) begin
      c_xck = (i % 5) != 4;
      #1;
      check_eq("lo_co", {31'b0, lo_co}, (c % 16 == 15) ? 1 : 0);
      check_eq("hi_co", {31'b0, hi_co}, (c == 255) ? 1 : 0);
      if (c_xck) c = (c + 1) % 256;
      csb.push_back(c);
      @(posedge clk);
      #1;
      check_eq("casc_q", {24'b0, hi_q, lo_q}, csb.pop_front());
      if (c >= 14 && c <= 16 || c == 0)
        $display("txn cascade xck=%b -> value=%02h", c_xck, {hi_q, lo_q});
    end
    check_eq("sb_empty", sb.size() + csb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
